// File: rtl/freq_meter_pkg.sv
// Shared types and board constants for the edge-counting frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } fm_state_t;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEFAULT_GATE = CLK_HZ;

endpackage

// File: rtl/freq_meter_chk.sv
// Elaboration-time parameter sanity checks for freq_meter.
module freq_meter_chk #(
    parameter int GATE_CYCLES = 100,
    parameter int GATE_WIDTH  = 7,
    parameter int CNT_WIDTH   = 8
) ();

    // The gate counter must be able to reach GATE_CYCLES-1, and a window needs two cycles.
    if ((64'(GATE_CYCLES) > (64'd1 << GATE_WIDTH)) || (GATE_CYCLES < 2)) begin : g_bad_gate
        $error("freq_meter: GATE_CYCLES=%0d invalid for GATE_WIDTH=%0d", GATE_CYCLES, GATE_WIDTH);
    end

    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("freq_meter: CNT_WIDTH must be at least 1");
    end

endmodule

// File: rtl/freq_meter_edge_sync.sv
// Brings the asynchronous input into the clock domain and emits a one-cycle
// registered pulse on each synchronized rising edge.
module edge_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sig,
    output logic o_edge
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic edge_r;
    logic edge_s;

    assign edge_s = sync2_r & ~prev_r;

    // Synchronizer, history flop and registered edge pulse; only reset clears them.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= i_sig;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            edge_r  <= edge_s;
        end
    end

    assign o_edge = edge_r;

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of i_sig over back-to-back gate windows of
// GATE_CYCLES clocks and publishes the saturated count once per window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE,
    parameter int GATE_WIDTH  = 26,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_sig,
    input  logic                 i_enable,
    output logic [CNT_WIDTH-1:0] o_freq,
    output logic                 o_valid,
    output logic                 o_overflow,
    output logic                 o_busy
);

    localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [GATE_WIDTH-1:0] GATE_ZERO = {GATE_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

    // Returns {increment attempted at max, saturated next count}.
    function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 inc);
        logic [CNT_WIDTH:0] res;
        if (!inc) begin
            res = {1'b0, cnt};
        end else if (cnt == CNT_MAX) begin
            res = {1'b1, cnt};
        end else begin
            res = {1'b0, cnt + CNT_WIDTH'(1)};
        end
        return res;
    endfunction

    fm_state_t              state_r;
    fm_state_t              state_s;
    logic [GATE_WIDTH-1:0]  gate_cnt_r;
    logic [GATE_WIDTH-1:0]  gate_cnt_s;
    logic [CNT_WIDTH-1:0]   edge_cnt_r;
    logic [CNT_WIDTH-1:0]   edge_cnt_s;
    logic                   sat_r;
    logic                   sat_s;
    logic [CNT_WIDTH-1:0]   freq_r;
    logic [CNT_WIDTH-1:0]   freq_s;
    logic                   valid_r;
    logic                   valid_s;
    logic                   overflow_r;
    logic                   overflow_s;
    logic                   busy_r;
    logic                   edge_s;
    logic [CNT_WIDTH:0]     inc_s;
    logic [CNT_WIDTH-1:0]   inc_cnt_s;
    logic                   inc_hit_s;

    freq_meter_chk #(
        .GATE_CYCLES (GATE_CYCLES),
        .GATE_WIDTH  (GATE_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_chk ();

    edge_sync u_edge_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_sig     (i_sig),
        .o_edge    (edge_s)
    );

    assign inc_s     = sat_inc(edge_cnt_r, edge_s);
    assign inc_cnt_s = inc_s[CNT_WIDTH-1:0];
    assign inc_hit_s = inc_s[CNT_WIDTH];

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, window counters and result publication.
    always_comb begin
        state_s    = state_r;
        gate_cnt_s = gate_cnt_r;
        edge_cnt_s = edge_cnt_r;
        sat_s      = sat_r;
        freq_s     = freq_r;
        overflow_s = overflow_r;
        valid_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_enable) begin
                    state_s    = MEASURE;
                    gate_cnt_s = GATE_ZERO;
                    edge_cnt_s = CNT_ZERO;
                    sat_s      = 1'b0;
                end else begin
                    state_s    = IDLE;
                end
            end
            MEASURE: begin
                if (gate_cnt_r == GATE_LAST) begin
                    // The final cycle's edge still belongs to this window.
                    freq_s     = inc_cnt_s;
                    overflow_s = sat_r | inc_hit_s;
                    valid_s    = 1'b1;
                    gate_cnt_s = GATE_ZERO;
                    edge_cnt_s = CNT_ZERO;
                    sat_s      = 1'b0;
                    if (i_enable) begin
                        state_s = MEASURE;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (!i_enable) begin
                    state_s = IDLE;
                end else begin
                    gate_cnt_s = gate_cnt_r + GATE_WIDTH'(1);
                    edge_cnt_s = inc_cnt_s;
                    sat_s      = sat_r | inc_hit_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gate_cnt_r <= GATE_ZERO;
            edge_cnt_r <= CNT_ZERO;
            sat_r      <= 1'b0;
            freq_r     <= CNT_ZERO;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            gate_cnt_r <= gate_cnt_s;
            edge_cnt_r <= edge_cnt_s;
            sat_r      <= sat_s;
            freq_r     <= freq_s;
            valid_r    <= valid_s;
            overflow_r <= overflow_s;
            busy_r     <= (state_s == MEASURE);
        end
    end

    assign o_freq     = freq_r;
    assign o_valid    = valid_r;
    assign o_overflow = overflow_r;
    assign o_busy     = busy_r;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: table-driven windows plus random input checked against
// a sample-history model, with two counter widths driven in parallel.
module tb_freq_meter;

    localparam int G     = 100;
    localparam int M_LO  = 0;
    localparam int M_HI  = 1;
    localparam int M_SQ  = 2;
    localparam int M_RND = 3;
    localparam int M_PUL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sig;
    logic       en;
    logic [7:0] freq8;
    logic       v8, ov8, b8;
    logic [3:0] freq4;
    logic       v4, ov4, b4;

    freq_meter #(.GATE_CYCLES(G), .GATE_WIDTH(7), .CNT_WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_sig(sig), .i_enable(en),
        .o_freq(freq8), .o_valid(v8), .o_overflow(ov8), .o_busy(b8));

    freq_meter #(.GATE_CYCLES(G), .GATE_WIDTH(7), .CNT_WIDTH(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_sig(sig), .i_enable(en),
        .o_freq(freq4), .o_valid(v4), .o_overflow(ov4), .o_busy(b4));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start    = 0;
    int mode     = M_LO;
    int period   = 10;
    int phase    = 0;
    int pa       = -100;
    int pb       = -100;
    int last8    = 0;
    int last4    = 0;
    int lastov4  = 0;
    bit samp [0:16383];

    // Pin value seen at each clock edge; reset holds the synchronizer at zero.
    always @(posedge clk) begin
        if (cyc < 16384) samp[cyc] <= rst_n ? sig : 1'b0;
        cyc <= cyc + 1;
    end

    // Input generator, updated on the falling edge.
    initial begin : drv
        int run;
        run = 0;
        sig = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                M_LO:  sig = 1'b0;
                M_HI:  sig = 1'b1;
                M_SQ:  sig = (((cyc + phase) % period) < (period / 2));
                M_RND: begin
                    if (run <= 1) begin
                        sig = ~sig;
                        run = $urandom_range(9, 2);
                    end else begin
                        run = run - 1;
                    end
                end
                M_PUL: sig = ((cyc >= pa) && (cyc < pa + 4)) || ((cyc >= pb) && (cyc < pb + 4));
                default: sig = 1'b0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // An edge whose first high sample is at s lands in the window cycle s+2-start.
    function automatic int count_win(input int s);
        int n = 0;
        for (int i = s - 2; i <= s + G - 3; i++)
            if (i >= 1 && samp[i] && !samp[i-1]) n++;
        return n;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic start_meas();
        @(negedge clk);
        en    = 1'b1;
        start = cyc;
    endtask

    task automatic check_window(input int w, input bit drop, input int e8, input int e4, input int eo4);
        int sw;
        int n;
        bit early;
        bit dropb;
        sw    = start + G * w;
        early = 1'b0;
        dropb = 1'b0;
        while (cyc < sw + G + 1) begin
            @(negedge clk);
            if (cyc < sw + G + 1) begin
                if (v8 || v4) early = 1'b1;
                if (!b8 || !b4) dropb = 1'b1;
                if (drop && cyc == sw + G) en = 1'b0;
            end
        end
        n = count_win(sw);
        check("no_early_valid", early, 0);
        check("busy_held", dropb, 0);
        check("valid_at_window_end", {v8, v4}, 3);
        check("freq8_model", freq8, sat(n, 255));
        check("ovf8_model", ov8, (n > 255) ? 1 : 0);
        check("freq4_model", freq4, sat(n, 15));
        check("ovf4_model", ov4, (n > 15) ? 1 : 0);
        if (e8 >= 0) begin
            check("freq8_table", freq8, e8);
            check("freq4_table", freq4, e4);
            check("ovf4_table", ov4, eo4);
        end
        check("busy_after_window", {b8, b4}, drop ? 0 : 3);
        last8   = sat(n, 255);
        last4   = sat(n, 15);
        lastov4 = (n > 15) ? 1 : 0;
        if (drop) begin
            @(negedge clk);
            check("valid_one_cycle", {v8, v4}, 0);
        end
    endtask

    typedef struct {
        int mode;
        int period;
        int nwin;
        int e8;
        int e4;
        int eo4;
    } row_t;

    row_t rows [6];

    initial begin
        bit bad;
        rows[0] = '{M_SQ, 10, 5, 10, 10, 0};
        rows[1] = '{M_SQ,  4, 2, 25, 15, 1};
        rows[2] = '{M_SQ, 20, 2,  5,  5, 0};
        rows[3] = '{M_HI,  0, 2,  0,  0, 0};
        rows[4] = '{M_LO,  0, 2,  0,  0, 0};
        rows[5] = '{M_SQ, 10, 1, 10, 10, 0};

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dut8", {freq8, v8, ov8, b8}, 0);
        check("reset_dut4", {freq4, v4, ov4, b4}, 0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (b8 || b4 || v8 || v4) bad = 1'b1;
        end
        check("idle_after_reset", bad, 0);

        for (int r = 0; r < 6; r++) begin
            mode   = rows[r].mode;
            period = (rows[r].period > 0) ? rows[r].period : 10;
            phase  = $urandom_range(period - 1, 0);
            repeat (10) @(negedge clk);
            start_meas();
            for (int w = 0; w < rows[r].nwin; w++)
                check_window(w, (w == rows[r].nwin - 1), rows[r].e8, rows[r].e4, rows[r].eo4);
        end

        // Abort in the middle of a window: nothing published, result held.
        start_meas();
        while (cyc < start + 50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy_low", {b8, b4}, 0);
        bad = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (v8 || v4) bad = 1'b1;
        end
        check("abort_no_valid", bad, 0);
        check("abort_freq8_held", freq8, last8);
        check("abort_freq4_held", freq4, last4);
        check("abort_ovf4_held", ov4, lastov4);
        start_meas();
        check_window(0, 1'b1, 10, 10, 0);

        // Random pulse widths of at least two cycles.
        mode = M_RND;
        repeat (10) @(negedge clk);
        start_meas();
        for (int w = 0; w < 4; w++) check_window(w, (w == 3), -1, -1, -1);

        // Single pulses just before and just after a window boundary.
        mode = M_LO;
        repeat (10) @(negedge clk);
        start_meas();
        pa   = start + G - 3;
        pb   = start + 2 * G - 2;
        mode = M_PUL;
        check_window(0, 1'b0, 1, 1, 0);
        check_window(1, 1'b0, 0, 0, 0);
        check_window(2, 1'b1, 1, 1, 0);

        // Asynchronous reset in the middle of an active window.
        mode   = M_SQ;
        period = 10;
        start_meas();
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_dut8", {freq8, v8, ov8, b8}, 0);
        check("midreset_dut4", {freq4, v4, ov4, b4}, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (b8 || b4 || v8 || v4) bad = 1'b1;
        end
        check("idle_after_midreset", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
